// File: rtl/mul_unit_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and
// the default operand width.
package mul_unit_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : mul_unit_pkg

// File: rtl/mul_unit_if.sv
// Request/response bundle of the multiplier. The master issues operations
// and the slave (mul_unit) returns the result with its flags.
interface mul_unit_if #(
    parameter int WIDTH = mul_unit_pkg::DEF_WIDTH
);
    logic             start;
    logic             opMla;
    logic [WIDTH-1:0] SrcN;
    logic [WIDTH-1:0] SrcM;
    logic [WIDTH-1:0] SrcA;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             FlagN;
    logic             FlagZ;

    modport master (
        output start, opMla, SrcN, SrcM, SrcA,
        input  busy, done, Result, FlagN, FlagZ
    );

    modport slave (
        input  start, opMla, SrcN, SrcM, SrcA,
        output busy, done, Result, FlagN, FlagZ
    );
endinterface : mul_unit_if

// File: rtl/mul_fsm.sv
// Sequencer of the multiplier: IDLE -> RUN (WIDTH steps) -> DONE -> IDLE.
// busy and done are registered outputs, so they trail the state by one
// edge: done pulses in the cycle after the DONE state, and busy covers the
// whole operation from the accepting edge through the done pulse.
module mul_fsm
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start_i,
    output state_e state_o,
    output logic   busy_o,
    output logic   done_o
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic          done_q;

    // State, step counter and registered busy/done in one sequential block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values of the others, whatever the statement order.
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule : mul_fsm

// File: rtl/mul_unit.sv
// Iterative shift-add multiplier (MUL / MLA), one multiplier bit per cycle,
// fixed latency regardless of operand values. Only the low WIDTH bits of the
// product (plus accumulate operand) are kept.
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clk,
    input  logic       reset,
    mul_unit_if.slave  bus
);
    state_e           fsm_state;
    logic             fsm_busy;
    logic             fsm_done;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic             flag_n_q;
    logic             flag_z_q;

    mul_fsm #(.WIDTH(WIDTH)) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .start_i (bus.start),
        .state_o (fsm_state),
        .busy_o  (fsm_busy),
        .done_o  (fsm_done)
    );

    // Datapath: load operands on accept, shift-add while running, capture
    // the accumulator and its flags when the sequence completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: operand registers are reset too, so an abandoned
            // operation leaves no stale values behind.
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b1;
        end else begin
            unique case (fsm_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= bus.SrcN;
                        mplier_q <= bus.SrcM;
                        acc_q    <= bus.opMla ? bus.SrcA : '0;
                    end
                end
                ST_RUN: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                end
                ST_DONE: begin
                    result_q <= acc_q;
                    flag_n_q <= acc_q[WIDTH-1];
                    flag_z_q <= (acc_q == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = fsm_busy;
    assign bus.done   = fsm_done;
    assign bus.Result = result_q;
    assign bus.FlagN  = flag_n_q;
    assign bus.FlagZ  = flag_z_q;

endmodule : mul_unit

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: expected results are queued when an
// operation is issued and compared when done pulses.
module tb_mul_unit;
    import mul_unit_pkg::*;

    localparam int W       = DEF_WIDTH;
    localparam int LAT     = W + 2;    // edges from accepting edge to done
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [W-1:0] res;
        logic         n;
        logic         z;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];

    mul_unit_if #(.WIDTH(W)) bus ();

    mul_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic mla, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] c);
        exp_t e;
        logic [W-1:0] r;
        r = a * b;
        if (mla) r = r + c;
        e.res = r;
        e.n   = r[W-1];
        e.z   = (r == '0);
        return e;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Pop the oldest expected result and compare against the outputs now.
    task automatic check_result(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: done with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            cmp({name, "_result"}, bus.Result, e.res);
            cmp({name, "_flagN"}, W'(bus.FlagN), W'(e.n));
            cmp({name, "_flagZ"}, W'(bus.FlagZ), W'(e.z));
        end
    endtask

    // Issue one operation (called at a negedge with the DUT idle), wait for
    // done with a bounded wait, check latency/result, pulse width and hold.
    task automatic do_op(input string name, input logic mla, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c);
        int n;
        logic [W-1:0] held;
        bus.opMla = mla;
        bus.SrcN  = a;
        bus.SrcM  = b;
        bus.SrcA  = c;
        bus.start = 1'b1;
        sb.push_back(model(mla, a, b, c));
        @(posedge clk);
        n = 1;
        forever begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n == 1) cmp({name, "_busy_run"}, W'(bus.busy), W'(1));
            if (bus.done === 1'b1) break;
            if (n >= TIMEOUT) break;
            @(posedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d edges", name, n);
            sb.delete();
        end else begin
            cmp({name, "_latency"}, W'(n), W'(LAT));
            cmp({name, "_busy_done"}, W'(bus.busy), W'(1));
            check_result(name);
            held = bus.Result;
            repeat (2) @(negedge clk);
            cmp({name, "_done_pulse"}, W'(bus.done), W'(0));
            cmp({name, "_busy_idle"}, W'(bus.busy), W'(0));
            cmp({name, "_hold"}, bus.Result, held);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.opMla = 1'b0;
        bus.SrcN  = '0;
        bus.SrcM  = '0;
        bus.SrcA  = '0;
        repeat (3) @(negedge clk);
        cmp("rst_busy", W'(bus.busy), W'(0));
        cmp("rst_done", W'(bus.done), W'(0));
        cmp("rst_result", bus.Result, '0);
        cmp("rst_flagN", W'(bus.FlagN), W'(0));
        cmp("rst_flagZ", W'(bus.FlagZ), W'(1));
        reset = 1'b1;
    endtask

    task automatic test_mul_basic();
        do_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'd0);
    endtask

    task automatic test_mla();
        do_op("mla_7x6p100", 1'b1, 32'd7, 32'd6, 32'd100);
        do_op("mul_7x6_ignA", 1'b0, 32'd7, 32'd6, 32'd100);
    endtask

    task automatic test_boundaries();
        do_op("mul_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        do_op("mul_msb", 1'b0, 32'h8000_0000, 32'd1, 32'd0);
        do_op("mul_zero", 1'b0, 32'd0, 32'h1234, 32'd0);
        do_op("mla_wrap", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF);
    endtask

    // start held high with operands changing every cycle: only the operands
    // at each accepting edge (every LAT edges) may reach the result.
    task automatic test_back_to_back();
        logic mla;
        logic [W-1:0] a, b, c;
        for (int e = 0; e < 3 * LAT; e++) begin
            mla = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            c   = $urandom;
            bus.opMla = mla;
            bus.SrcN  = a;
            bus.SrcM  = b;
            bus.SrcA  = c;
            bus.start = 1'b1;
            if (e % LAT == 0) sb.push_back(model(mla, a, b, c));
            @(posedge clk);
            @(negedge clk);
            cmp($sformatf("b2b_busy_%0d", e), W'(bus.busy), W'(1));
            cmp($sformatf("b2b_done_%0d", e), W'(bus.done), W'(e % LAT == LAT - 1));
            if (bus.done === 1'b1) check_result($sformatf("b2b_op_%0d", e / LAT));
        end
        bus.start = 1'b0;
        @(negedge clk);
        cmp("b2b_idle_busy", W'(bus.busy), W'(0));
        cmp("b2b_sb_empty", W'(sb.size()), W'(0));
    endtask

    task automatic test_reset_midrun();
        do_op("pre_11x13", 1'b0, 32'd11, 32'd13, 32'd0);
        bus.opMla = 1'b0;
        bus.SrcN  = 32'd1234;
        bus.SrcM  = 32'd5678;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("mid_rst_busy", W'(bus.busy), W'(0));
        cmp("mid_rst_done", W'(bus.done), W'(0));
        cmp("mid_rst_result", bus.Result, '0);
        cmp("mid_rst_flagZ", W'(bus.FlagZ), W'(1));
        @(negedge clk);
        reset = 1'b1;
        do_op("post_2x9", 1'b0, 32'd2, 32'd9, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul_basic();
        test_mla();
        test_boundaries();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mul_unit
